// File: rtl/branch_predict_pc.sv
// branch_predict_pc: owns the fetch PC. It predicts at IF with a direct-mapped
// BTB of 2-bit saturating counters and resolves beq/bne and j/jal at ID.
// On a mispredict or a jump it redirects the PC and flushes IF/ID. It also
// counts resolved taken branches and mispredicts.
module branch_predict_pc #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  output logic [WIDTH-1:0]     pc_o,
  output logic                 pred_taken_o,
  input  logic                 branch_i,
  input  logic                 bne_i,
  input  logic                 equal_i,
  input  logic [WIDTH-1:0]     id_pc_i,
  input  logic                 id_pred_taken_i,
  input  logic [WIDTH-1:0]     id_target_i,
  input  logic                 jump_i,
  input  logic [WIDTH-1:0]     jump_target_i,
  output logic                 flush_o,
  output logic [CNT_WIDTH-1:0] taken_cnt_o,
  output logic [CNT_WIDTH-1:0] mispred_cnt_o
);

  localparam int unsigned      IDX_W  = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(4);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] tag;
    logic [WIDTH-1:0] target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t           btb_q [DEPTH];
  btb_entry_t           if_entry;
  btb_entry_t           id_entry;
  btb_entry_t           entry_d;
  logic                 btb_we;

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]     if_idx, id_idx;
  logic                 if_hit, id_hit;
  logic                 pred_taken;
  logic [WIDTH-1:0]     pred_next;
  logic                 taken, mispred, upd_en, flush;

  // IF lookup: the prediction comes from the entry indexed by the current PC.
  always_comb begin
    if_idx     = pc_q[IDX_W+1:2];
    if_entry   = btb_q[if_idx];
    if_hit     = if_entry.valid && (if_entry.tag == pc_q);
    pred_taken = if_hit && if_entry.ctr[1];
    pred_next  = pred_taken ? if_entry.target : pc_q + PC_INC;
  end

  // ID resolution and next-PC selection: a jump beats a mispredict, and a mispredict beats the prediction.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    pc_d    = pc_q;
    flush   = 1'b0;
    taken   = branch_i && (bne_i ? !equal_i : equal_i);
    mispred = branch_i && !jump_i && (taken != id_pred_taken_i);
    if (!stall_i) begin
      if (jump_i) begin
        pc_d  = jump_target_i;
        flush = 1'b1;
      end else if (mispred) begin
        pc_d  = taken ? id_target_i : id_pc_i + PC_INC;
        flush = 1'b1;
      end else begin
        pc_d  = pred_next;
      end
    end
  end

  // BTB training and performance counters for a resolved conditional branch.
  always_comb begin
    upd_en        = branch_i && !jump_i && !stall_i;
    id_idx        = id_pc_i[IDX_W+1:2];
    id_entry      = btb_q[id_idx];
    id_hit        = id_entry.valid && (id_entry.tag == id_pc_i);
    entry_d       = id_entry;
    btb_we        = 1'b0;
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en) begin
      if (id_hit) begin
        btb_we         = 1'b1;
        entry_d.target = id_target_i;
        if (taken) begin
          if (id_entry.ctr != 2'b11) entry_d.ctr = id_entry.ctr + 2'd1;
        end else begin
          if (id_entry.ctr != 2'b00) entry_d.ctr = id_entry.ctr - 2'd1;
        end
      end else if (taken) begin
        // A taken miss allocates over whatever occupied the slot.
        btb_we         = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = id_pc_i;
        entry_d.target = id_target_i;
        entry_d.ctr    = 2'b10;
      end
      if (taken)   taken_cnt_d   = taken_cnt_q + CNT_WIDTH'(1);
      if (mispred) mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  // PC and counter registers. A stall holds them because the _d values equal the _q values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      pc_q          <= pc_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // BTB storage. The IF lookup reads the old entry, and a write becomes visible in the next cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: this array is reset explicitly because valid bits and counters must start known; it is small and lives in flops, not RAM.
      for (int i = 0; i < int'(DEPTH); i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= 2'b01;
      end
    end else if (btb_we) begin
      btb_q[id_idx] <= entry_d;
    end
  end

  assign pc_o          = pc_q;
  assign pred_taken_o  = pred_taken;
  assign flush_o       = flush;
  assign taken_cnt_o   = taken_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule
